// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer for uart_Rx: gates the receiver reset, turns level flags into frame
// events, buffers words in a show-ahead FIFO and keeps saturating error statistics.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic [DATA_BITS-1:0]          rx_data_i,
  input  logic                          rx_valid_i,
  input  logic                          rx_parity_err_i,
  input  logic                          rx_stop_err_i,
  output logic                          rx_rst_o,
  input  logic                          rd_en_i,
  output logic [DATA_BITS-1:0]          rd_data_o,
  output logic                          rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overrun_o,
  input  logic                          clear_stats_i,
  output logic [CNT_W-1:0]              parity_err_cnt_o,
  output logic [CNT_W-1:0]              stop_err_cnt_o,
  output logic [CNT_W-1:0]              overrun_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ARM = 2'd1,
    ST_RUN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_rst_q, rx_rst_d;
  logic                   hist_vld_q, hist_par_q, hist_stop_q;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   overrun_q, overrun_d;
  logic [CNT_W-1:0]       par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0]       stop_cnt_q, stop_cnt_d;
  logic [CNT_W-1:0]       ovr_cnt_q, ovr_cnt_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic run, vld_ev, par_ev, stop_ev, full, pop, push, ovr_ev;

  always_comb begin
    state_d  = state_q;
    rx_rst_d = 1'b1;
    unique case (state_q)
      ST_OFF:  if (enable_i) state_d = ST_ARM;
      ST_ARM:  state_d = enable_i ? ST_RUN : ST_OFF;
      ST_RUN:  if (!enable_i) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase
    rx_rst_d = (state_d == ST_OFF);
  end

  // Events only count in RUN; ARM merely primes the history so stale levels are ignored.
  assign run     = (state_q == ST_RUN);
  assign vld_ev  = run && rx_valid_i      && !hist_vld_q;
  assign par_ev  = run && rx_parity_err_i && !hist_par_q;
  assign stop_ev = run && rx_stop_err_i   && !hist_stop_q;

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign pop    = rd_en_i && (count_q != '0);
  assign push   = vld_ev && (!full || pop);
  assign ovr_ev = vld_ev && full && !pop;

  function automatic logic [CNT_W-1:0] stat_next(input logic [CNT_W-1:0] cur,
                                                 input logic ev, input logic clr);
    if (clr)              return ev ? CNT_W'(1) : '0;
    if (ev && cur != '1)  return cur + CNT_W'(1);
    return cur;
  endfunction

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    par_cnt_d  = stat_next(par_cnt_q,  par_ev,  clear_stats_i);
    stop_cnt_d = stat_next(stop_cnt_q, stop_ev, clear_stats_i);
    ovr_cnt_d  = stat_next(ovr_cnt_q,  ovr_ev,  clear_stats_i);
    overrun_d  = clear_stats_i ? ovr_ev : (overrun_q || ovr_ev);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_OFF;
      rx_rst_q    <= 1'b1;
      hist_vld_q  <= 1'b0;
      hist_par_q  <= 1'b0;
      hist_stop_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      par_cnt_q   <= '0;
      stop_cnt_q  <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rx_rst_q <= rx_rst_d;
      if (state_q != ST_OFF) begin
        hist_vld_q  <= rx_valid_i;
        hist_par_q  <= rx_parity_err_i;
        hist_stop_q <= rx_stop_err_i;
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      par_cnt_q  <= par_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) mem_q[wr_ptr_q] <= rx_data_i;
  end

  assign rx_rst_o         = rx_rst_q;
  assign rd_data_o        = mem_q[rd_ptr_q];
  assign rd_valid_o       = (count_q != '0);
  assign fifo_count_o     = count_q;
  assign overrun_o        = overrun_q;
  assign parity_err_cnt_o = par_cnt_q;
  assign stop_err_cnt_o   = stop_cnt_q;
  assign overrun_cnt_o    = ovr_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random traffic, checked against a
// queue-based reference model with a decoupled read-side scoreboard monitor.
module tb_uart_rx_ctrl;

  localparam int D   = 16;
  localparam int MAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, rx_parity_err = 1'b0, rx_stop_err = 1'b0;
  logic       rd_en = 1'b0, clear_stats = 1'b0;
  logic       rx_rst, rd_valid, overrun;
  logic [7:0] rd_data, par_cnt, stop_cnt, ovr_cnt;
  logic [4:0] fifo_count;

  uart_rx_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(D), .CNT_W(8)) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_parity_err_i(rx_parity_err), .rx_stop_err_i(rx_stop_err),
    .rx_rst_o(rx_rst), .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .fifo_count_o(fifo_count), .overrun_o(overrun), .clear_stats_i(clear_stats),
    .parity_err_cnt_o(par_cnt), .stop_err_cnt_o(stop_cnt), .overrun_cnt_o(ovr_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: words held, stats, and what enable looked like at recent edges.
  logic [7:0] expq[$];
  int  m_cnt = 0, m_par = 0, m_stop = 0, m_ovc = 0;
  bit  m_ovr = 0, m_rxrst = 1, started = 0;
  bit  en1 = 0, en2 = 0, hv = 0, hp = 0, hs = 0;

  function automatic int sat_inc(int v, bit ev, bit clr);
    if (clr) return ev ? 1 : 0;
    if (ev && v < MAX) return v + 1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      expq.delete();
      m_cnt = 0; m_par = 0; m_stop = 0; m_ovc = 0; m_ovr = 0;
      en1 = 0; en2 = 0; hv = 0; hp = 0; hs = 0;
      m_rxrst = 1; started = 1;
    end else begin
      bit running, ev_v, ev_p, ev_s, pop, ovr_ev;
      // Receiving requires enable to have been seen at the two previous edges (arm, then run).
      running = en1 && en2;
      ev_v = running && rx_valid && !hv;
      ev_p = running && rx_parity_err && !hp;
      ev_s = running && rx_stop_err && !hs;
      pop  = rd_en && (m_cnt > 0);
      ovr_ev = 0;
      if (ev_v) begin
        if (m_cnt < D || pop) expq.push_back(rx_data);
        else ovr_ev = 1;
      end
      m_cnt = m_cnt + ((ev_v && !ovr_ev) ? 1 : 0) - (pop ? 1 : 0);
      m_par  = sat_inc(m_par, ev_p, clear_stats);
      m_stop = sat_inc(m_stop, ev_s, clear_stats);
      m_ovc  = sat_inc(m_ovc, ovr_ev, clear_stats);
      m_ovr  = clear_stats ? ovr_ev : (m_ovr || ovr_ev);
      if (en1) begin hv = rx_valid; hp = rx_parity_err; hs = rx_stop_err; end
      en2 = en1;
      en1 = enable;
      m_rxrst = !enable;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: status every cycle, and a scoreboard pop whenever the DUT presents a word being taken.
  always @(negedge clk) begin
    if (started) begin
      chk("rx_rst", 32'(rx_rst), 32'(m_rxrst));
      chk("rd_valid", 32'(rd_valid), 32'(m_cnt != 0));
      chk("fifo_count", 32'(fifo_count), 32'(m_cnt));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("parity_err_cnt", 32'(par_cnt), 32'(m_par));
      chk("stop_err_cnt", 32'(stop_cnt), 32'(m_stop));
      chk("overrun_cnt", 32'(ovr_cnt), 32'(m_ovc));
      if (rd_en && rd_valid === 1'b1) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_data: DUT offered 0x%0h but no word was expected", rd_data);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(expq.pop_front()));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [7:0] d, input bit with_pop);
    rx_data = d; rx_valid = 1'b1; rd_en = with_pop;
    cyc(1);
    rd_en = 1'b0;
    cyc($urandom_range(0, 2));
    rx_valid = 1'b0;
    cyc(1);
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1; cyc(n); rd_en = 1'b0; cyc(1);
  endtask

  initial begin
    cyc(3);
    reset = 1'b0; cyc(2);

    // Stale rx_valid held across arming must not push.
    enable = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE; cyc(4);
    rx_valid = 1'b0; cyc(2);

    send(8'h55, 0); send(8'hA3, 0); send(8'h00, 0);
    tests++;
    if (fifo_count !== 5'd3) begin
      fails++; $display("FAIL three_frames: fifo_count 0x%0h, expected 0x3", fifo_count);
    end
    drain(4);

    // Fill, overflow once, then overflow-with-pop which must push.
    repeat (D) send(8'($urandom), 0);
    send(8'hBB, 0);
    send(8'hCC, 1);
    drain(D + 6);
    send(8'h7E, 0);
    drain(2);

    // Saturation, then clear coinciding with a stop error.
    repeat (300) begin rx_parity_err = 1'b1; cyc(1); rx_parity_err = 1'b0; cyc(1); end
    rx_stop_err = 1'b1; clear_stats = 1'b1; cyc(1);
    clear_stats = 1'b0; rx_stop_err = 1'b0; cyc(1);

    // Reset mid-stream with words held and counters nonzero.
    repeat (5) send(8'($urandom), 0);
    repeat (2) begin rx_parity_err = 1'b1; cyc(1); rx_parity_err = 1'b0; cyc(1); end
    rx_valid = 1'b1; rx_data = 8'h99; cyc(1);
    reset = 1'b1; cyc(1);
    reset = 1'b0; rx_valid = 1'b0; enable = 1'b0; cyc(2);
    enable = 1'b1; cyc(3);
    send(8'h3C, 0);
    drain(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (enable) enable = ($urandom_range(0, 99) >= 2);
      else        enable = ($urandom_range(0, 99) < 30);
      if (rx_valid) rx_valid = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 99) < 35) begin rx_valid = 1'b1; rx_data = 8'($urandom); end
      rx_parity_err = ($urandom_range(0, 9) == 0);
      rx_stop_err   = ($urandom_range(0, 9) == 0);
      rd_en         = ($urandom_range(0, 99) < ((i < 1500) ? 15 : 50));
      clear_stats   = ($urandom_range(0, 49) == 0);
      reset         = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    reset = 1'b0; rx_valid = 1'b0; rx_parity_err = 1'b0; rx_stop_err = 1'b0;
    clear_stats = 1'b0; enable = 1'b0;
    drain(D + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
